// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter: loads a WIDTH-bit word and emits it one bit at a time,
// each bit held DIV cycles, with optional continuous looping and back-to-back reloads.
module bit_serializer #(
   parameter int WIDTH     = 16,
   parameter int DIV       = 1,
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     load_valid,
   input  logic [WIDTH-1:0]         load_data,
   input  logic                     load_loop,
   input  logic                     stop,
   output logic                     load_ready,
   output logic                     out,
   output logic                     out_valid,
   output logic [$clog2(WIDTH)-1:0] bit_idx,
   output logic                     done
);

   localparam int BW = $clog2(WIDTH);
   localparam int HW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);
   localparam logic [HW-1:0] LAST_HOLD = HW'(DIV - 1);
   localparam logic [BW-1:0] ONE_B     = BW'(1);
   localparam logic [HW-1:0] ONE_H     = HW'(1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_word, w_word_nxt;
   logic             r_loop, w_loop_nxt;
   logic [BW-1:0]    r_bit, w_bit_nxt;
   logic [HW-1:0]    r_hold, w_hold_nxt;
   logic             w_final;
   logic             w_load;
   logic [BW-1:0]    w_pos;

   // State, word, loop flag and counters; reset clears everything asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_word  <= {WIDTH{1'b0}};
         r_loop  <= 1'b0;
         r_bit   <= {BW{1'b0}};
         r_hold  <= {HW{1'b0}};
      end else begin
         r_state <= w_state_nxt;
         r_word  <= w_word_nxt;
         r_loop  <= w_loop_nxt;
         r_bit   <= w_bit_nxt;
         r_hold  <= w_hold_nxt;
      end
   end

   // Handshake, next-state and counter sequencing
   always_comb begin
      w_state_nxt = r_state;
      w_word_nxt  = r_word;
      w_loop_nxt  = r_loop;
      w_bit_nxt   = r_bit;
      w_hold_nxt  = r_hold;

      w_final = (r_state == SHIFT) && (r_hold == LAST_HOLD) && (r_bit == LAST_BIT);

      // A reload is only offered at the very end of a non-looping pass, and stop vetoes it
      if (rst) begin
         load_ready = 1'b0;
      end else if (r_state == IDLE) begin
         load_ready = 1'b1;
      end else if (w_final && !r_loop && !stop) begin
         load_ready = 1'b1;
      end else begin
         load_ready = 1'b0;
      end

      w_load = load_valid && load_ready;

      case (r_state)
         IDLE: begin
            if (w_load) begin
               w_state_nxt = SHIFT;
               w_word_nxt  = load_data;
               w_loop_nxt  = load_loop;
               w_bit_nxt   = {BW{1'b0}};
               w_hold_nxt  = {HW{1'b0}};
            end else begin
               w_state_nxt = IDLE;
            end
         end
         SHIFT: begin
            if (stop) begin
               w_state_nxt = IDLE;
               w_bit_nxt   = {BW{1'b0}};
               w_hold_nxt  = {HW{1'b0}};
            end else if (w_load) begin
               w_state_nxt = SHIFT;
               w_word_nxt  = load_data;
               w_loop_nxt  = load_loop;
               w_bit_nxt   = {BW{1'b0}};
               w_hold_nxt  = {HW{1'b0}};
            end else if (r_hold == LAST_HOLD) begin
               w_hold_nxt = {HW{1'b0}};
               if (r_bit != LAST_BIT) begin
                  w_bit_nxt = r_bit + ONE_B;
               end else if (r_loop) begin
                  w_bit_nxt = {BW{1'b0}};
               end else begin
                  w_state_nxt = IDLE;
                  w_bit_nxt   = {BW{1'b0}};
               end
            end else begin
               w_hold_nxt = r_hold + ONE_H;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_bit_nxt   = {BW{1'b0}};
            w_hold_nxt  = {HW{1'b0}};
         end
      endcase
   end

   // Serial outputs are decoded purely from registered state
   always_comb begin
      w_pos     = LSB_FIRST ? r_bit : (LAST_BIT - r_bit);
      out_valid = (r_state == SHIFT);
      bit_idx   = r_bit;
      done      = w_final;
      if (r_state == SHIFT) begin
         out = r_word[w_pos];
      end else begin
         out = 1'b0;
      end
   end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench: a per-cycle vector table for the 16-bit MSB/LSB-first instances, then
// hand-written sequences for hold division, looping, stop, back-to-back loads and reset.
module tb_bit_serializer;

   logic clk;
   logic rst;

   logic        lv16, loop16, stop16;
   logic [15:0] ld_a, ld_b;
   logic        rdy0, out0, val0, done0;
   logic [3:0]  idx0;
   logic        rdy1, out1, val1, done1;
   logic [3:0]  idx1;

   logic        lv2, loop2, stop2;
   logic [3:0]  d2;
   logic        rdy2, out2, val2, done2;
   logic [1:0]  idx2;

   logic        lv3, loop3, stop3;
   logic [3:0]  d3;
   logic        rdy3, out3, val3, done3;
   logic [1:0]  idx3;

   int n_pass;
   int n_total;

   bit_serializer #(.WIDTH(16), .DIV(1), .LSB_FIRST(1'b0)) u0 (
      .clk(clk), .rst(rst), .load_valid(lv16), .load_data(ld_a), .load_loop(loop16),
      .stop(stop16), .load_ready(rdy0), .out(out0), .out_valid(val0), .bit_idx(idx0),
      .done(done0));

   bit_serializer #(.WIDTH(16), .DIV(1), .LSB_FIRST(1'b1)) u1 (
      .clk(clk), .rst(rst), .load_valid(lv16), .load_data(ld_b), .load_loop(loop16),
      .stop(stop16), .load_ready(rdy1), .out(out1), .out_valid(val1), .bit_idx(idx1),
      .done(done1));

   bit_serializer #(.WIDTH(4), .DIV(3), .LSB_FIRST(1'b0)) u2 (
      .clk(clk), .rst(rst), .load_valid(lv2), .load_data(d2), .load_loop(loop2),
      .stop(stop2), .load_ready(rdy2), .out(out2), .out_valid(val2), .bit_idx(idx2),
      .done(done2));

   bit_serializer #(.WIDTH(4), .DIV(1), .LSB_FIRST(1'b0)) u3 (
      .clk(clk), .rst(rst), .load_valid(lv3), .load_data(d3), .load_loop(loop3),
      .stop(stop3), .load_ready(rdy3), .out(out3), .out_valid(val3), .bit_idx(idx3),
      .done(done3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        lv;
      logic [15:0] da;
      logic [15:0] db;
      logic        loop;
      logic        stop;
      logic        e_out0;
      logic        e_out1;
      logic        e_val;
      logic [3:0]  e_idx;
      logic        e_done;
      logic        e_rdy;
   } vec_t;

   vec_t tbl [18];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   initial begin
      logic [3:0] exp_a;
      logic [3:0] exp_b;
      n_pass  = 0;
      n_total = 0;
      rst = 1'b0;
      lv16 = 1'b0; loop16 = 1'b0; stop16 = 1'b0; ld_a = 16'h0000; ld_b = 16'h0000;
      lv2 = 1'b0; loop2 = 1'b0; stop2 = 1'b0; d2 = 4'h0;
      lv3 = 1'b0; loop3 = 1'b0; stop3 = 1'b0; d3 = 4'h0;

      // Row 0 loads; rows 1..16 carry the serial pass with junk on the data/loop inputs
      tbl[0] = '{1'b1, 16'h8001, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1};
      for (int k = 1; k <= 16; k++) begin
         tbl[k] = '{1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, (k == 1 || k == 16), (k <= 2),
                    1'b1, 4'(k - 1), (k == 16), (k == 16)};
      end
      tbl[17] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1};

      #1 rst = 1'b1;
      #1;
      chk("rst_rdy0", 32'(rdy0), 32'd0);
      chk("rst_val0", 32'(val0), 32'd0);
      chk("rst_out0", 32'(out0), 32'd0);
      chk("rst_idx0", 32'(idx0), 32'd0);
      chk("rst_done0", 32'(done0), 32'd0);
      chk("rst_rdy2", 32'(rdy2), 32'd0);

      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 18; i++) begin
         if (i != 0) @(negedge clk);
         lv16 = tbl[i].lv; ld_a = tbl[i].da; ld_b = tbl[i].db;
         loop16 = tbl[i].loop; stop16 = tbl[i].stop;
         #1;
         chk($sformatf("tbl%0d_out0", i), 32'(out0), 32'(tbl[i].e_out0));
         chk($sformatf("tbl%0d_out1", i), 32'(out1), 32'(tbl[i].e_out1));
         chk($sformatf("tbl%0d_val0", i), 32'(val0), 32'(tbl[i].e_val));
         chk($sformatf("tbl%0d_val1", i), 32'(val1), 32'(tbl[i].e_val));
         chk($sformatf("tbl%0d_idx0", i), 32'(idx0), 32'(tbl[i].e_idx));
         chk($sformatf("tbl%0d_idx1", i), 32'(idx1), 32'(tbl[i].e_idx));
         chk($sformatf("tbl%0d_done0", i), 32'(done0), 32'(tbl[i].e_done));
         chk($sformatf("tbl%0d_done1", i), 32'(done1), 32'(tbl[i].e_done));
         chk($sformatf("tbl%0d_rdy0", i), 32'(rdy0), 32'(tbl[i].e_rdy));
         chk($sformatf("tbl%0d_rdy1", i), 32'(rdy1), 32'(tbl[i].e_rdy));
      end
      lv16 = 1'b0; loop16 = 1'b0;

      // DIV=3, WIDTH=4, word 1010: each bit held three cycles
      @(negedge clk);
      lv2 = 1'b1; d2 = 4'b1010;
      #1 chk("div_rdy_idle", 32'(rdy2), 32'd1);
      @(negedge clk);
      lv2 = 1'b0; d2 = 4'b0101;
      for (int c = 1; c <= 12; c++) begin
         #1;
         chk($sformatf("div_c%0d_out", c), 32'(out2), 32'(((c - 1) / 3) % 2 == 0));
         chk($sformatf("div_c%0d_done", c), 32'(done2), 32'(c == 12));
         chk($sformatf("div_c%0d_idx", c), 32'(idx2), 32'((c - 1) / 3));
         @(negedge clk);
      end
      #1 chk("div_end_val", 32'(val2), 32'd0);

      // Looping word 1100; stop on a final cycle still pulses done and blocks the load
      @(negedge clk);
      lv3 = 1'b1; d3 = 4'b1100; loop3 = 1'b1;
      #1 chk("loop_rdy_idle", 32'(rdy3), 32'd1);
      @(negedge clk);
      lv3 = 1'b0; loop3 = 1'b0; d3 = 4'b0000;
      for (int c = 1; c <= 8; c++) begin
         if (c == 8) begin
            stop3 = 1'b1; lv3 = 1'b1;
         end
         #1;
         chk($sformatf("loop_c%0d_out", c), 32'(out3), 32'(((c - 1) % 4) < 2));
         chk($sformatf("loop_c%0d_done", c), 32'(done3), 32'(c % 4 == 0));
         chk($sformatf("loop_c%0d_rdy", c), 32'(rdy3), 32'd0);
         @(negedge clk);
      end
      stop3 = 1'b0; lv3 = 1'b0;
      #1;
      chk("stopfin_val", 32'(val3), 32'd0);
      chk("stopfin_done", 32'(done3), 32'd0);

      // stop is ignored in IDLE; then a mid-pass stop ends the transfer without done
      lv3 = 1'b1; d3 = 4'b1100; loop3 = 1'b1; stop3 = 1'b1;
      #1 chk("idle_stop_rdy", 32'(rdy3), 32'd1);
      @(negedge clk);
      lv3 = 1'b0; loop3 = 1'b0; stop3 = 1'b0;
      #1;
      chk("midstop_c1_val", 32'(val3), 32'd1);
      chk("midstop_c1_out", 32'(out3), 32'd1);
      @(negedge clk);
      stop3 = 1'b1;
      #1;
      chk("midstop_c2_done", 32'(done3), 32'd0);
      chk("midstop_c2_rdy", 32'(rdy3), 32'd0);
      @(negedge clk);
      stop3 = 1'b0;
      #1;
      chk("midstop_after_val", 32'(val3), 32'd0);
      chk("midstop_after_done", 32'(done3), 32'd0);

      // Back-to-back: A=1001 then B=0110 with load_valid held high
      exp_a = 4'b1001;
      exp_b = 4'b0110;
      lv3 = 1'b1; d3 = exp_a; loop3 = 1'b0;
      #1 chk("b2b_rdy_idle", 32'(rdy3), 32'd1);
      @(negedge clk);
      d3 = exp_b;
      for (int c = 1; c <= 4; c++) begin
         #1;
         chk($sformatf("b2b_a%0d_out", c), 32'(out3), 32'(exp_a[4 - c]));
         chk($sformatf("b2b_a%0d_rdy", c), 32'(rdy3), 32'(c == 4));
         chk($sformatf("b2b_a%0d_done", c), 32'(done3), 32'(c == 4));
         @(negedge clk);
      end
      lv3 = 1'b0; d3 = 4'b0000;
      for (int c = 5; c <= 8; c++) begin
         #1;
         chk($sformatf("b2b_b%0d_val", c), 32'(val3), 32'd1);
         chk($sformatf("b2b_b%0d_out", c), 32'(out3), 32'(exp_b[8 - c]));
         chk($sformatf("b2b_b%0d_done", c), 32'(done3), 32'(c == 8));
         @(negedge clk);
      end
      #1 chk("b2b_end_val", 32'(val3), 32'd0);

      // Asynchronous reset at bit_idx 7, then a fresh 8001 transfer
      @(negedge clk);
      lv16 = 1'b1; ld_a = 16'h8001; loop16 = 1'b0;
      @(negedge clk);
      lv16 = 1'b0;
      repeat (7) @(negedge clk);
      #1 chk("arst_pre_idx", 32'(idx0), 32'd7);
      #2 rst = 1'b1;
      #1;
      chk("arst_val", 32'(val0), 32'd0);
      chk("arst_out", 32'(out0), 32'd0);
      chk("arst_idx", 32'(idx0), 32'd0);
      chk("arst_done", 32'(done0), 32'd0);
      chk("arst_rdy", 32'(rdy0), 32'd0);
      @(negedge clk);
      rst = 1'b0; lv16 = 1'b1; ld_a = 16'h8001;
      #1 chk("arst_rel_rdy", 32'(rdy0), 32'd1);
      @(negedge clk);
      lv16 = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         #1;
         chk($sformatf("post_c%0d_out", c), 32'(out0), 32'(c == 1 || c == 16));
         chk($sformatf("post_c%0d_done", c), 32'(done0), 32'(c == 16));
         @(negedge clk);
      end
      #1 chk("post_end_val", 32'(val0), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the number of bits per word (min 2).
REQ-002 The block SHALL have parameter DIV, default 1, giving clock cycles each bit is held (min 1).
REQ-003 The block SHALL have parameter LSB_FIRST, default 0; 0 sends data[WIDTH-1] first, 1 sends data[0] first.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset: clk, input, 1, rising-edge clock; rst, input, 1, asynchronous active-high reset.
REQ-005 load_valid  input  1  request to load load_data.
REQ-006 load_data  input  WIDTH  word to serialize.
REQ-007 load_loop  input  1  captured with the word; 1 means repeat the word until stopped.
REQ-008 stop  input  1  abort or end the current transfer.
REQ-009 load_ready  output  1  block can accept a word this cycle.
REQ-010 out  output  1  current serial bit.
REQ-011 out_valid  output  1  out carries a data bit.
REQ-012 bit_idx  output  $clog2(WIDTH)  position in the sequence of the bit on out (0 = first sent).
REQ-013 done  output  1  one-cycle pulse on the final cycle of each complete pass.

Function
REQ-014 The block SHALL implement states IDLE and SHIFT, with a word register, a loop flag, a bit counter (0..WIDTH-1) and a hold counter (0..DIV-1).
REQ-015 Handshake: a load SHALL occur on a rising clk edge with load_valid=1, load_ready=1 and rst=0; a load captures load_data and load_loop, clears both counters, and enters SHIFT.
REQ-016 load_ready SHALL be 1 in IDLE, and 1 in SHIFT only on the final hold cycle of bit WIDTH-1 when the loop flag is 0; it SHALL be 0 otherwise.
REQ-017 out_valid SHALL be 1 exactly when in SHIFT; out SHALL be 0 and bit_idx SHALL be 0 in IDLE.
REQ-018 In SHIFT, out SHALL equal word[WIDTH-1-bit_idx] when LSB_FIRST=0 and word[bit_idx] when LSB_FIRST=1.
REQ-019 Latency: the first bit SHALL appear on out in the cycle after the load edge.
REQ-020 Each bit SHALL be held for exactly DIV cycles, then bit_idx increments by 1.
REQ-021 done SHALL be 1 on the last hold cycle of bit WIDTH-1 and 0 otherwise.
REQ-022 Wrap-around: at the end of bit WIDTH-1, the block SHALL return to bit_idx 0 of the same word when the loop flag is 1, and SHALL go to IDLE when the loop flag is 0.
REQ-023 Back-to-back: a load accepted on the final cycle of a pass SHALL start the new word with no idle cycle, and that load takes precedence over the return to IDLE.
REQ-024 stop=1 in SHIFT SHALL force IDLE on the next edge with no done pulse, unless that cycle is the final cycle of a pass, in which case done still pulses.
REQ-025 stop=1 SHALL take precedence over a simultaneous load_valid; with stop=1, load_ready SHALL be 0 in SHIFT, and stop SHALL have no effect in IDLE.
REQ-026 load_data and load_loop SHALL be ignored outside a load edge, and changes to them mid-transfer SHALL not affect the output.

Reset
REQ-027 rst=1 SHALL immediately force IDLE and clear the word register, loop flag and both counters, regardless of clk.
REQ-028 While rst=1, outputs SHALL be out=0, out_valid=0, bit_idx=0, done=0 and load_ready=0.
REQ-029 On the first edge after rst falls, load_ready SHALL be 1 and a load may occur.
REQ-030 Reset asserted mid-transfer SHALL drop the transfer with no done pulse.

Verification
REQ-031 WIDTH=16, DIV=1, LSB_FIRST=0, load 16'h8001 at edge T -> out=1 at T+1, 0 for T+2..T+15, 1 at T+16; done only at T+16; out_valid=0 at T+17.
REQ-032 LSB_FIRST=1, load 16'h0003 -> out sequence 1,1 then 14 zeros; bit_idx counts 0..15.
REQ-033 DIV=3, WIDTH=4, load 4'b1010 -> out 1,1,1,0,0,0,1,1,1,0,0,0; done on cycle 12 only.
REQ-034 Loop=1, WIDTH=4, word 4'b1100 -> pattern repeats with done every 4 cycles; stop mid-pass -> out_valid=0 on the next cycle with no done.
REQ-035 Back-to-back: hold load_valid=1 with words A then B -> B's first bit follows A's last bit with no gap, and load_ready=1 only on the final cycle of A.
REQ-036 Assert rst at bit_idx=7 between clock edges -> outputs clear immediately; after release, a fresh load behaves as in REQ-031.
